// File: rtl/iob_ptfloat_pack.sv
// pt-float pack: normalises a signed (exponent, fraction) pair, picks the minimal exponent
// width, rounds the mantissa and emits one DATA_W-bit word. Define PTFLOAT_PACK_RNE_EN for RNE rounding.
`ifndef EXP_MAX_W
`define EXP_MAX_W 16
`endif
`ifndef MAN_MAX_W
`define MAN_MAX_W 32
`endif

module iob_ptfloat_pack #(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic signed [`EXP_MAX_W-1:0] exp_i,
    input  logic signed [`MAN_MAX_W-1:0] man_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic        [DATA_W-1:0]     data_o
);

    localparam int EXP_W     = `EXP_MAX_W;
    localparam int MAN_W     = `MAN_MAX_W;
    localparam int XW        = EXP_W + 1;
    localparam int EW_LIM    = DATA_W - EW_W - 2;
    localparam int EW_MAX    = ((2**EW_W - 1) < EW_LIM) ? (2**EW_W - 1) : EW_LIM;
    localparam int DROP_BASE = MAN_W - DATA_W + EW_W;

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_WIDTH, S_ROUND, S_DONE} state_t;

    typedef struct packed {
        logic              carry;
        logic [DATA_W-1:0] word;
    } round_t;

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    exp_q, exp_d;
    logic signed [MAN_W-1:0] man_q, man_d;
    logic [EW_W-1:0]         ew_q, ew_d;
    logic [DATA_W-1:0]       data_q, data_d;
    int                      ewm;
    round_t                  rnd;

    // Smallest two's-complement width holding e; zero needs no bits at all.
    function automatic int ew_min(input logic signed [XW-1:0] e);
        logic [XW-1:0] m;
        int            bl;
        m  = e[XW-1] ? ~e : e;
        bl = 0;
        for (int i = 0; i < XW; i++) begin
            if (m[i]) bl = i + 1;
        end
        if (e == '0) return 0;
        return bl + 1;
    endfunction

    function automatic logic [DATA_W-1:0] sat_word(input logic neg);
        logic [DATA_W-1:0] exp_max, msb, mant;
        exp_max = (DATA_W'(1) << (EW_MAX - 1)) - DATA_W'(1);
        msb     = DATA_W'(1) << (DATA_W - 1);
        mant    = neg ? msb : ((msb - DATA_W'(1)) & ~((DATA_W'(1) << (EW_W + EW_MAX)) - DATA_W'(1)));
        return mant | (exp_max << EW_W) | DATA_W'(EW_MAX);
    endfunction

    // Keeps the top MW bits of m; carry flags a positive round-up that overflowed the sign.
    function automatic round_t round_pack(input logic signed [MAN_W-1:0] m,
                                          input logic signed [XW-1:0]    e,
                                          input logic [EW_W-1:0]         ew);
        int                    drop, mw;
        logic signed [MAN_W:0] kept, kept_rnd, top, one;
        logic                  rnd_up;
        logic [DATA_W-1:0]     mant_f, exp_f;
        round_t                r;
`ifdef PTFLOAT_PACK_RNE_EN
        logic [MAN_W-1:0]      ones, half, rem;
`endif
        drop = DROP_BASE + int'(ew);
        mw   = DATA_W - EW_W - int'(ew);
        kept = {m[MAN_W-1], m};
        kept = kept >>> drop;
`ifdef PTFLOAT_PACK_RNE_EN
        ones   = '1;
        half   = (drop > 0) ? (MAN_W'(1) << (drop - 1)) : '0;
        rem    = m & ~(ones << drop);
        rnd_up = (|(rem & half)) && ((|(rem & (half - MAN_W'(1)))) || kept[0]);
`else
        rnd_up = 1'b0;
`endif
        kept_rnd = kept + {{MAN_W{1'b0}}, rnd_up};
        one      = 1;
        top      = one << (mw - 1);
        r.carry  = rnd_up && (kept_rnd == top);
        mant_f   = DATA_W'(kept_rnd) << (EW_W + int'(ew));
        exp_f    = (DATA_W'(e) & ~({DATA_W{1'b1}} << ew)) << EW_W;
        r.word   = mant_f | exp_f | DATA_W'(ew);
        return r;
    endfunction

    always_comb ewm = ew_min(exp_q);
    always_comb rnd = round_pack(man_q, exp_q, ew_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        man_d   = man_q;
        ew_d    = ew_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    exp_d   = {exp_i[EXP_W-1], exp_i};
                    man_d   = man_i;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Zero falls through to WIDTH, which emits the all-zero word.
                if (man_q != '0 && man_q[MAN_W-1] == man_q[MAN_W-2]) begin
                    man_d = man_q <<< 1;
                    exp_d = exp_q - XW'(1);
                end else begin
                    state_d = S_WIDTH;
                end
            end
            S_WIDTH: begin
                if (man_q == '0) begin
                    data_d  = '0;
                    state_d = S_DONE;
                end else if (ewm > EW_MAX) begin
                    data_d  = exp_q[XW-1] ? '0 : sat_word(man_q[MAN_W-1]);
                    state_d = S_DONE;
                end else begin
                    ew_d    = EW_W'(ewm);
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd.carry) begin
                    man_d   = man_q >>> 1;
                    exp_d   = exp_q + XW'(1);
                    state_d = S_WIDTH;
                end else begin
                    data_d  = rnd.word;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
        exp_q <= exp_d;
        man_q <= man_d;
        ew_q  <= ew_d;
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign data_o = data_q;

endmodule

// File: tb/tb_iob_ptfloat_pack.sv
// Bench for iob_ptfloat_pack: spec vectors, reset/ignored-start sequences and a
// randomized run against a value-level reference model.
`ifndef EXP_MAX_W
`define EXP_MAX_W 16
`endif
`ifndef MAN_MAX_W
`define MAN_MAX_W 32
`endif

module tb_iob_ptfloat_pack;

    localparam int DATA_W = 32;
    localparam int EW_W   = 4;
    localparam int EXP_W  = `EXP_MAX_W;
    localparam int MAN_W  = `MAN_MAX_W;
    localparam int EW_MAX = ((2**EW_W - 1) < (DATA_W - EW_W - 2)) ? (2**EW_W - 1) : (DATA_W - EW_W - 2);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic signed [EXP_W-1:0]  exp_in = '0;
    logic signed [MAN_W-1:0]  man_in = '0;
    logic                     busy, done;
    logic [DATA_W-1:0]        data;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    iob_ptfloat_pack #(.DATA_W(DATA_W), .EW_W(EW_W)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .exp_i  (exp_in),
        .man_i  (man_in),
        .busy_o (busy),
        .done_o (done),
        .data_o (data)
    );

    typedef struct {
        logic [31:0] man;
        int          exp;
        logic [31:0] word;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: value = m * 2^e, normalise, pick width, round, re-normalise on carry.
    function automatic void model(input longint m0, input int e0, output longint word, output int lat);
        longint m, q, rem, scale, lim;
        int     e, k, c, ew, mw, drop;
        logic   up;
        m = m0; e = e0; k = 0; c = 0;
        word = 0;
        lat  = 3;
        if (m == 0) return;
        lim = longint'(1) << (MAN_W - 2);
        while (m >= -lim && m < lim) begin
            m = m * 2; e = e - 1; k++;
        end
        for (int it = 0; it < 4; it++) begin
            ew = 0;
            for (int w = 0; w < 40; w++) begin
                if ((w == 0 && e == 0) ||
                    (w > 0 && e >= -(1 << (w - 1)) && e < (1 << (w - 1)))) begin
                    ew = w;
                    break;
                end
            end
            if (ew > EW_MAX) begin
                mw = DATA_W - EW_W - EW_MAX;
                if (e > 0)
                    word = ((m < 0 ? (longint'(1) << (mw - 1)) : ((longint'(1) << (mw - 1)) - 1)) << (EW_W + EW_MAX))
                         | (((longint'(1) << (EW_MAX - 1)) - 1) << EW_W) | EW_MAX;
                else
                    word = 0;
                lat = 3 + k + 2 * c;
                return;
            end
            drop  = MAN_W - DATA_W + EW_W + ew;
            mw    = DATA_W - EW_W - ew;
            scale = longint'(1) << drop;
            q     = m >>> drop;
            rem   = m - q * scale;
            up    = 1'b0;
`ifdef PTFLOAT_PACK_RNE_EN
            up = (2 * rem > scale) || (2 * rem == scale && q[0]);
`endif
            if (up) q = q + 1;
            if (q >= (longint'(1) << (mw - 1))) begin
                m = m >>> 1; e = e + 1; c++;
                continue;
            end
            word = ((q & ((longint'(1) << mw) - 1)) << (EW_W + ew))
                 | ((longint'(e) & ((longint'(1) << ew) - 1)) << EW_W) | ew;
            word = word & 64'hFFFF_FFFF;
            lat  = 4 + k + 2 * c;
            return;
        end
    endfunction

    // Launch one op and wait for done; returns word and cycles from start to done.
    task automatic run_op(input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e,
                          output logic [DATA_W-1:0] word, output int lat);
        @(negedge clk);
        man_in = m;
        exp_in = e;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        word = data;
        @(posedge clk); #1;
        chk("done_pulse_width", longint'(done), 0);
        chk("data_held", longint'(data), longint'(word));
    endtask

    initial begin
        vec_t               vecs[7];
        logic [DATA_W-1:0]  w;
        int                 lat, seen, x;
        longint             mw_exp;
        int                 ml;
        logic signed [MAN_W-1:0] mv;
        logic signed [EXP_W-1:0] ev;

        vecs[0] = '{32'h0000_0000,      5, 32'h0000_0000, 3};
        vecs[1] = '{32'h4000_0000,      0, 32'h4000_0000, 4};
        vecs[2] = '{32'h1000_0000,      3, 32'h4000_0012, 6};
        vecs[3] = '{32'h8000_0000,     -1, 32'h8000_0011, 4};
`ifdef PTFLOAT_PACK_RNE_EN
        vecs[4] = '{32'h7FFF_FFFF,      0, 32'h4000_0012, 6};
`else
        vecs[4] = '{32'h7FFF_FFFF,      0, 32'h7FFF_FFF0, 4};
`endif
        vecs[5] = '{32'h4000_0000,  20000, 32'h7FFB_FFFF, 3};
        vecs[6] = '{32'h4000_0000, -20000, 32'h0000_0000, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_data", longint'(data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].man, EXP_W'(vecs[i].exp), w, lat);
            chk($sformatf("vec%0d_data", i), longint'(w), longint'(vecs[i].word));
            chk($sformatf("vec%0d_latency", i), longint'(lat), longint'(vecs[i].lat));
        end

        // Reset two cycles into a normalising op: op is dropped.
        run_op(32'h4000_0000, EXP_W'(0), w, lat);
        @(negedge clk);
        man_in = 32'h1000_0000; exp_in = EXP_W'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midop_reset_busy", longint'(busy), 0);
        chk("midop_reset_data", longint'(data), 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("midop_reset_no_done", longint'(seen), 0);

        // Start while busy and start during DONE are both ignored.
        @(negedge clk);
        man_in = 32'h1000_0000; exp_in = EXP_W'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        @(posedge clk); #1;
        lat++;
        man_in = '0; exp_in = '0; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_start_latency", longint'(lat), 6);
        chk("busy_start_data", longint'(data), 64'h4000_0012);
        man_in = 32'h4000_0000; exp_in = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("extra_done_count", longint'(seen), 0);
        chk("idle_after_ignored", longint'(busy), 0);

        // Randomized run against the reference model.
        for (int n = 0; n < 250; n++) begin
            mv = MAN_W'($urandom);
            mv = mv >>> $urandom_range(0, MAN_W - 1);
            if ($urandom_range(0, 15) == 0) mv = '0;
            case ($urandom_range(0, 9))
                6:       x = 16370 + int'($urandom_range(0, 40));
                7:       x = -16420 + int'($urandom_range(0, 60));
                8:       x = ($urandom_range(0, 1) == 1) ? 30000 + int'($urandom_range(0, 2767))
                                                         : -32768 + int'($urandom_range(0, 2767));
                9:       x = int'($urandom_range(0, 10)) - 5;
                default: x = int'($urandom_range(0, 80)) - 40;
            endcase
            ev = EXP_W'(x);
            model(longint'(mv), int'(ev), mw_exp, ml);
            run_op(mv, ev, w, lat);
            chk($sformatf("rand%0d_data m=%h e=%0d", n, mv, ev), longint'(w), mw_exp);
            chk($sformatf("rand%0d_latency", n), longint'(lat), longint'(ml));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
